mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory port arbiter.
//   state_e        - arbiter FSM states
//   req_id_e       - requester identity (instruction fetch / data load)
//   LD_SIZE_*      - ld_size encodings
//   DEPTH_DEFAULT  - default program memory size in bytes
//   size_to_bytes  - byte count for a load size encoding
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_id_e;

  localparam logic [1:0] LD_SIZE_BYTE     = 2'd0;
  localparam logic [1:0] LD_SIZE_HALF     = 2'd1;
  localparam logic [1:0] LD_SIZE_WORD     = 2'd2;
  localparam logic [1:0] LD_SIZE_WORD_ALT = 2'd3;

  localparam int unsigned DEPTH_DEFAULT = 501;

  // Number of bytes transferred for a load of the given size.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      LD_SIZE_BYTE: n = 3'd1;
      LD_SIZE_HALF: n = 3'd2;
      default:      n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide combinational memory read port
// between an instruction-fetch requester and a data-load requester.
// Accesses are assembled big-endian, one byte per cycle.
//   clk, rst                  - clock, synchronous active-high reset
//   if_req/if_addr            - fetch request (always 4 bytes)
//   if_valid/if_data          - fetch completion pulse and word
//   ld_req/ld_addr/ld_size    - load request (1/2/4 bytes)
//   ld_valid/ld_data          - load completion pulse and zero-extended value
//   err                       - with a valid: some byte address was >= DEPTH
//   mem_en/mem_addr/mem_rdata - byte read port
//   busy                      - arbiter not idle
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  req_id_e           id_q, id_d;
  req_id_e           last_q, last_d;
  req_id_e           grant_id_s;
  logic              any_req_s;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       sr_q, sr_d;
  logic              err_flag_q, err_flag_d;
  logic              if_valid_q, if_valid_d;
  logic              ld_valid_q, ld_valid_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              oor_s;
  logic [7:0]        byte_s;

  // Out-of-range bytes read as zero; memory data is ignored for them.
  assign oor_s  = (mem_addr_q >= DEPTH_A);
  assign byte_s = oor_s ? 8'h00 : mem_rdata;

  // Round-robin choice: on a tie the requester not granted last wins.
  always_comb begin
    any_req_s  = if_req | ld_req;
    grant_id_s = REQ_IF;
    if (if_req && ld_req) begin
      grant_id_s = (last_q == REQ_IF) ? REQ_LD : REQ_IF;
    end else if (ld_req) begin
      grant_id_s = REQ_LD;
    end else begin
      grant_id_s = REQ_IF;
    end
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    last_d     = last_q;
    base_d     = base_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    err_flag_d = err_flag_q;
    if_data_d  = if_data_q;
    ld_data_d  = ld_data_q;
    if_valid_d = 1'b0;
    ld_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_en_d   = 1'b0;
    mem_addr_d = {ADDR_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d    = ST_READ;
          id_d       = grant_id_s;
          last_d     = grant_id_s;
          base_d     = (grant_id_s == REQ_IF) ? if_addr : ld_addr;
          n_d        = (grant_id_s == REQ_IF) ? 3'd4 : size_to_bytes(ld_size);
          cnt_d      = 3'd0;
          sr_d       = 32'h0000_0000;
          err_flag_d = 1'b0;
          // mem_en/mem_addr are registered, so present the first byte
          // address as the FSM enters READ.
          mem_en_d   = 1'b1;
          mem_addr_d = base_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        sr_d       = {sr_q[23:0], byte_s};
        cnt_d      = cnt_q + 3'd1;
        err_flag_d = err_flag_q | oor_s;
        if (cnt_d == n_q) begin
          state_d = ST_DONE;
          err_d   = err_flag_d;
          if (id_q == REQ_IF) begin
            if_valid_d = 1'b1;
            if_data_d  = sr_d;
          end else begin
            ld_valid_d = 1'b1;
            ld_data_d  = sr_d;
          end
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + ADDR_W'(cnt_d);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= REQ_IF;
      last_q     <= REQ_LD;
      base_q     <= {ADDR_W{1'b0}};
      n_q        <= 3'd0;
      cnt_q      <= 3'd0;
      sr_q       <= 32'h0000_0000;
      err_flag_q <= 1'b0;
      if_valid_q <= 1'b0;
      ld_valid_q <= 1'b0;
      if_data_q  <= 32'h0000_0000;
      ld_data_q  <= 32'h0000_0000;
      err_q      <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      last_q     <= last_d;
      base_q     <= base_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      err_flag_q <= err_flag_d;
      if_valid_q <= if_valid_d;
      ld_valid_q <= ld_valid_d;
      if_data_q  <= if_data_d;
      ld_data_q  <= ld_data_d;
      err_q      <= err_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_data  = if_data_q;
  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;
  assign err      = err_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus randomized
// episodes checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int DEPTH = 501;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_valid;
  logic [31:0] if_data;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [1:0]  ld_size = 2'd0;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [0:DEPTH-1];

  int n_checks = 0;
  int n_bad    = 0;
  bit last_was_ld = 1'b1;
  logic [31:0] exp_if_data = 32'd0;
  logic [31:0] exp_ld_data = 32'd0;

  mem_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory returns junk outside its range so a DUT using it is caught.
  always_comb begin
    if (mem_addr < 32'(DEPTH)) mem_rdata = mem[mem_addr[8:0]];
    else                       mem_rdata = 8'hA5;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  // Reference: {err, value} of an n-byte big-endian read at address a.
  function automatic logic [32:0] ref_access(input logic [31:0] a, input int n);
    logic [31:0] v;
    logic [31:0] ai;
    logic        e;
    v = 32'd0;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v  = v << 8;
      if (ai < 32'(DEPTH)) v[7:0] = mem[ai[8:0]];
      else e = 1'b1;
    end
    return {e, v};
  endfunction

  // One episode: raise the chosen requests together while the DUT is idle,
  // each drops its request once served. Checks order, latency, data, err,
  // data hold of the other port and memory-port activity.
  task automatic run_episode(input bit do_if, input logic [31:0] ia,
                             input bit do_ld, input logic [31:0] la, input logic [1:0] lsz);
    int n_if, n_ld, t_if, t_ld, en_cycles, addr_viol, k;
    bit if_first, got_if, got_ld;
    logic [32:0] r_if, r_ld;
    n_if = 4;
    n_ld = size_bytes(lsz);
    r_if = ref_access(ia, n_if);
    r_ld = ref_access(la, n_ld);
    if (do_if && do_ld) if_first = last_was_ld;
    else                if_first = do_if;
    // Each grant costs 1 grant cycle + N read cycles + 1 done cycle.
    if (if_first) begin
      t_if = n_if + 1;
      t_ld = n_if + 3 + n_ld;
    end else begin
      t_ld = n_ld + 1;
      t_if = n_ld + 3 + n_if;
    end
    last_was_ld = (do_if && do_ld) ? if_first : do_ld;
    got_if = 1'b0; got_ld = 1'b0; en_cycles = 0; addr_viol = 0;
    if_addr = ia; ld_addr = la; ld_size = lsz;
    if_req = do_if; ld_req = do_ld;
    k = 0;
    while (k < 40 && ((do_if && !got_if) || (do_ld && !got_ld))) begin
      @(posedge clk); #1;
      k++;
      en_cycles += int'(mem_en);
      if (!mem_en && mem_addr != 32'd0) addr_viol++;
      if (if_valid) begin
        if (!do_if || got_if) begin
          check_eq("if_spurious", {63'd0, if_valid}, 64'd0);
        end else begin
          check_eq("if_latency", 64'(k), 64'(t_if));
          check_eq("if_data", {32'd0, if_data}, {32'd0, r_if[31:0]});
          check_eq("if_err", {63'd0, err}, {63'd0, r_if[32]});
          check_eq("ld_data_hold", {32'd0, ld_data}, {32'd0, exp_ld_data});
          exp_if_data = r_if[31:0];
          got_if = 1'b1;
          if_req = 1'b0;
        end
      end
      if (ld_valid) begin
        if (!do_ld || got_ld) begin
          check_eq("ld_spurious", {63'd0, ld_valid}, 64'd0);
        end else begin
          check_eq("ld_latency", 64'(k), 64'(t_ld));
          check_eq("ld_data", {32'd0, ld_data}, {32'd0, r_ld[31:0]});
          check_eq("ld_err", {63'd0, err}, {63'd0, r_ld[32]});
          check_eq("if_data_hold", {32'd0, if_data}, {32'd0, exp_if_data});
          exp_ld_data = r_ld[31:0];
          got_ld = 1'b1;
          ld_req = 1'b0;
        end
      end
    end
    if (do_if) check_eq("if_served", {63'd0, got_if}, 64'd1);
    if (do_ld) check_eq("ld_served", {63'd0, got_ld}, 64'd1);
    if_req = 1'b0; ld_req = 1'b0;
    check_eq("mem_en_cycles", 64'(en_cycles), 64'((do_if ? n_if : 0) + (do_ld ? n_ld : 0)));
    check_eq("mem_addr_idle", 64'(addr_viol), 64'd0);
    // Leave DONE so the next episode starts in IDLE.
    @(posedge clk); #1;
    check_eq("busy_after", {63'd0, busy}, 64'd0);
  endtask

  // Both requesters held high continuously; grants must alternate.
  task automatic run_alternation(input logic [31:0] ia, input logic [31:0] la, input logic [1:0] lsz);
    int served, k;
    bit exp_ld;
    logic [32:0] r_if, r_ld;
    r_if = ref_access(ia, 4);
    r_ld = ref_access(la, size_bytes(lsz));
    exp_ld = !last_was_ld;
    served = 0;
    if_addr = ia; ld_addr = la; ld_size = lsz;
    if_req = 1'b1; ld_req = 1'b1;
    k = 0;
    while (k < 100 && served < 6) begin
      @(posedge clk); #1;
      k++;
      if (if_valid || ld_valid) begin
        check_eq("alt_order", {62'd0, ld_valid, if_valid}, exp_ld ? 64'd2 : 64'd1);
        if (ld_valid) check_eq("alt_ld_data", {32'd0, ld_data}, {32'd0, r_ld[31:0]});
        else          check_eq("alt_if_data", {32'd0, if_data}, {32'd0, r_if[31:0]});
        last_was_ld = ld_valid;
        exp_ld = !exp_ld;
        served++;
      end
    end
    check_eq("alt_count", 64'(served), 64'd6);
    if_req = 1'b0; ld_req = 1'b0;
    exp_if_data = r_if[31:0];
    exp_ld_data = r_ld[31:0];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h93;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check_eq("rst_ld_valid", {63'd0, ld_valid}, 64'd0);
    check_eq("rst_if_data", {32'd0, if_data}, 64'd0);
    check_eq("rst_ld_data", {32'd0, ld_data}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    check_eq("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check_eq("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    last_was_ld = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests after reset: fetch first.
    run_episode(1'b1, 32'd4, 1'b1, 32'd8, 2'd2);
    // Fetch of the reference word.
    run_episode(1'b1, 32'd0, 1'b0, 32'd0, 2'd0);
    // Byte and half loads.
    run_episode(1'b0, 32'd0, 1'b1, 32'd2, 2'd0);
    run_episode(1'b0, 32'd0, 1'b1, 32'd2, 2'd1);
    // Fetch crossing the end of memory.
    run_episode(1'b1, 32'd499, 1'b0, 32'd0, 2'd0);
    // Fetch wrapping the address space.
    run_episode(1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, 2'd0);

    // Reset during the second READ cycle of a fetch.
    if_addr = 32'd0; if_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_valid", {62'd0, if_valid, ld_valid}, 64'd0);
    check_eq("midrst_if_data", {32'd0, if_data}, 64'd0);
    rst = 1'b0; if_req = 1'b0;
    last_was_ld = 1'b1;
    exp_if_data = 32'd0; exp_ld_data = 32'd0;
    @(posedge clk); #1;
    run_episode(1'b1, 32'd0, 1'b0, 32'd0, 2'd0);

    // Continuous contention.
    run_alternation(32'd16, 32'd100, 2'd1);

    // Randomized episodes.
    for (int e = 0; e < 24; e++) begin
      bit di, dl;
      di = 1'($urandom);
      dl = 1'($urandom);
      if (!di && !dl) di = 1'b1;
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 3))
          0: rb = 32'($urandom_range(0, 20));
          1: rb = 32'($urandom_range(490, 510));
          2: rb = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
          default: rb = 32'($urandom_range(0, 500));
        endcase
        if (j == 0) ra = rb;
      end
      run_episode(di, ra, dl, rb, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
